// File: rtl/alu_flag_wb.sv
// ---------------------------------------------------------------------------
// alu_flag_wb : ALU writeback stage - 2-entry result FIFO, CCR update, branch conditions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_flag_wb #(
  parameter int          DEPTH     = 2,
  parameter logic [4:0]  CCR_RESET = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_xnzvc,
  input  logic [1:0]  in_size,
  input  logic [4:0]  in_flag_mask,
  input  logic        in_z_sticky,
  input  logic        ccr_wr,
  input  logic [4:0]  ccr_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_size,
  output logic [4:0]  ccr,
  input  logic [3:0]  cond_sel,
  output logic        cond_true
);

  localparam logic [1:0] c_full = 2'(DEPTH);

  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [31:0] r_res [2];
  logic [1:0]  r_sz  [2];
  logic [4:0]  r_ccr;

  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_size_norm;
  logic [4:0]  w_ccr_next;
  logic        w_n, w_z, w_v, w_c;

  // Handshake depends only on registered count, so no out_ready -> in_ready path.
  assign in_ready    = (r_count != c_full);
  assign out_valid   = (r_count != 2'd0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_size_norm = (in_size == 2'b11) ? 2'b10 : in_size;

  assign out_result  = r_res[r_rd_ptr];
  assign out_size    = r_sz[r_rd_ptr];
  assign ccr         = r_ccr;

  always_comb begin
    w_ccr_next = r_ccr;
    if (w_push) begin
      for (int i = 0; i < 5; i++) begin
        if (in_flag_mask[i]) w_ccr_next[i] = in_xnzvc[i];
      end
      // Extended ops can only clear Z so multi-precision zero tests chain correctly.
      if (in_flag_mask[2] && in_z_sticky) w_ccr_next[2] = r_ccr[2] & in_xnzvc[2];
    end
    if (ccr_wr) w_ccr_next = ccr_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ccr    <= CCR_RESET;
      for (int i = 0; i < 2; i++) begin
        r_res[i] <= 32'd0;
        r_sz[i]  <= 2'd0;
      end
    end else begin
      if (w_push) begin
        r_res[r_wr_ptr] <= in_result;
        r_sz[r_wr_ptr]  <= w_size_norm;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_ccr <= w_ccr_next;
    end
  end

  assign w_n = r_ccr[3];
  assign w_z = r_ccr[2];
  assign w_v = r_ccr[1];
  assign w_c = r_ccr[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = 1'b0;
      4'd2:  cond_true = ~w_c & ~w_z;
      4'd3:  cond_true = w_c | w_z;
      4'd4:  cond_true = ~w_c;
      4'd5:  cond_true = w_c;
      4'd6:  cond_true = ~w_z;
      4'd7:  cond_true = w_z;
      4'd8:  cond_true = ~w_v;
      4'd9:  cond_true = w_v;
      4'd10: cond_true = ~w_n;
      4'd11: cond_true = w_n;
      4'd12: cond_true = ~(w_n ^ w_v);
      4'd13: cond_true = w_n ^ w_v;
      4'd14: cond_true = ~w_z & ~(w_n ^ w_v);
      4'd15: cond_true = w_z | (w_n ^ w_v);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_flag_wb.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_wb : directed self-checking bench for alu_flag_wb
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_flag_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_xnzvc;
  logic [1:0]  in_size;
  logic [4:0]  in_flag_mask;
  logic        in_z_sticky;
  logic        ccr_wr;
  logic [4:0]  ccr_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_size;
  logic [4:0]  ccr;
  logic [3:0]  cond_sel;
  logic        cond_true;

  int checks = 0;
  int errors = 0;

  alu_flag_wb #(.DEPTH(2), .CCR_RESET(5'b00000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_xnzvc(in_xnzvc), .in_size(in_size), .in_flag_mask(in_flag_mask),
    .in_z_sticky(in_z_sticky), .ccr_wr(ccr_wr), .ccr_wdata(ccr_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_size(out_size), .ccr(ccr), .cond_sel(cond_sel), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_result = 0; in_xnzvc = 0; in_size = 0; in_flag_mask = 0;
    in_z_sticky = 0; ccr_wr = 0; ccr_wdata = 0; out_ready = 0; cond_sel = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (ccr !== 5'b00000) begin errors++; $display("FAIL reset_ccr got %b want 00000", ccr); end
    checks++; if (out_result !== 32'd0 || out_size !== 2'd0) begin errors++; $display("FAIL reset_head got %h/%b want 0/00", out_result, out_size); end
    cycle();
    rst_n = 1;
    cycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1; in_result = 32'h8000000F; in_xnzvc = 5'b01010; in_flag_mask = 5'b11111; in_size = 2'b10;
    cycle();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    checks++; if (out_result !== 32'h8000000F) begin errors++; $display("FAIL basic_result got %h want 8000000f", out_result); end
    checks++; if (out_size !== 2'b10) begin errors++; $display("FAIL basic_size got %b want 10", out_size); end
    checks++; if (ccr !== 5'b01010) begin errors++; $display("FAIL basic_ccr got %b want 01010", ccr); end
    cond_sel = 4'd12; #1;
    checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL basic_ge got %b want 1", cond_true); end
    cond_sel = 4'd13; #1;
    checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL basic_lt got %b want 0", cond_true); end
    cond_sel = 4'd11; #1;
    checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL basic_mi got %b want 1", cond_true); end
    // Pop the head while pushing a size-11 result that must come out as 10.
    out_ready = 1; in_valid = 1; in_result = 32'h00000055; in_size = 2'b11; in_flag_mask = 5'b00000;
    cycle();
    in_valid = 0;
    checks++; if (out_result !== 32'h00000055 || out_size !== 2'b10) begin errors++; $display("FAIL size_norm got %h/%b want 00000055/10", out_result, out_size); end
    cycle();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_flag_mask = 0; in_size = 2'b00;
    in_valid = 1; in_result = 32'hA;
    cycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
    in_result = 32'hB;
    cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after2 got %b want 0", in_ready); end
    in_result = 32'hC;
    cycle();
    checks++; if (in_ready !== 1'b0 || out_result !== 32'hA) begin errors++; $display("FAIL bp_hold got ready=%b head=%h want 0/a", in_ready, out_result); end
    checks++; if (out_size !== 2'b00) begin errors++; $display("FAIL bp_size got %b want 00", out_size); end
    out_ready = 1;
    cycle();
    checks++; if (out_result !== 32'hB || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 got head=%h ready=%b want b/1", out_result, in_ready); end
    cycle();
    in_valid = 0;
    checks++; if (out_result !== 32'hC || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain2 got head=%h valid=%b want c/1", out_result, out_valid); end
    cycle();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_flag_mask = 0;
    in_valid = 1; in_result = 32'd1; out_ready = 0;
    cycle();
    out_ready = 1;
    for (int k = 2; k <= 10; k++) begin
      in_result = k;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'(k)) begin
        errors++;
        $display("FAIL b2b_%0d got valid=%b ready=%b head=%0d want 1/1/%0d", k, out_valid, in_ready, out_result, k);
      end
    end
    in_valid = 0;
    cycle();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_sticky();
    out_ready = 1;
    ccr_wr = 1; ccr_wdata = 5'b00100;
    cycle();
    ccr_wr = 0;
    checks++; if (ccr !== 5'b00100) begin errors++; $display("FAIL sticky_set got %b want 00100", ccr); end
    in_valid = 1; in_xnzvc = 5'b00000; in_flag_mask = 5'b00100; in_z_sticky = 1;
    cycle();
    checks++; if (ccr !== 5'b00000) begin errors++; $display("FAIL sticky_clear got %b want 00000", ccr); end
    in_xnzvc = 5'b00100;
    cycle();
    checks++; if (ccr !== 5'b00000) begin errors++; $display("FAIL sticky_hold got %b want 00000", ccr); end
    in_z_sticky = 0;
    cycle();
    in_valid = 0;
    checks++; if (ccr !== 5'b00100) begin errors++; $display("FAIL nonsticky_set got %b want 00100", ccr); end
    cycle();
  endtask

  task automatic test_override();
    out_ready = 1;
    in_valid = 1; in_xnzvc = 5'b11111; in_flag_mask = 5'b00011; in_z_sticky = 0; in_result = 32'h1234;
    cycle();
    checks++; if (ccr !== 5'b00111) begin errors++; $display("FAIL mask_vc got %b want 00111", ccr); end
    in_result = 32'h5678; ccr_wr = 1; ccr_wdata = 5'b10000;
    cycle();
    in_valid = 0; ccr_wr = 0;
    checks++; if (ccr !== 5'b10000) begin errors++; $display("FAIL ccr_wr_override got %b want 10000", ccr); end
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h5678) begin errors++; $display("FAIL override_push got valid=%b head=%h want 1/5678", out_valid, out_result); end
    cycle();
    out_ready = 0;
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_flag_mask = 5'b11111; in_xnzvc = 5'b11011;
    in_valid = 1; in_result = 32'h111;
    cycle();
    in_result = 32'h222;
    cycle();
    in_valid = 0;
    checks++; if (in_ready !== 1'b0 || ccr !== 5'b11011) begin errors++; $display("FAIL arst_pre got ready=%b ccr=%b want 0/11011", in_ready, ccr); end
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || ccr !== 5'b00000) begin errors++; $display("FAIL arst_immediate got valid=%b ccr=%b want 0/00000", out_valid, ccr); end
    checks++; if (out_result !== 32'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_head got %h ready=%b want 0/1", out_result, in_ready); end
    cycle();
    rst_n = 1;
    cycle();
  endtask

  task automatic test_cond();
    logic [4:0]  ccr_vals [4];
    logic [15:0] exp_tab  [4];
    logic [15:0] tab;
    ccr_vals[0] = 5'b00000; exp_tab[0] = 16'h5555;
    ccr_vals[1] = 5'b01111; exp_tab[1] = 16'h9AA9;
    ccr_vals[2] = 5'b00010; exp_tab[2] = 16'hA655;
    ccr_vals[3] = 5'b00101; exp_tab[3] = 16'h95A9;
    for (int j = 0; j < 4; j++) begin
      ccr_wr = 1; ccr_wdata = ccr_vals[j];
      cycle();
      ccr_wr = 0;
      tab = exp_tab[j];
      for (int s = 0; s < 16; s++) begin
        cond_sel = 4'(s);
        #1;
        checks++;
        if (cond_true !== tab[s]) begin
          errors++;
          $display("FAIL cond_ccr%b_sel%0d got %b want %b", ccr_vals[j], s, cond_true, tab[s]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_override();
    test_async_reset();
    test_cond();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_flag_wb.md
Name: alu_flag_wb

Overview:
- Downstream writeback stage for the ALU.
- Accepts each ALU result with its XNZVC flags through a valid/ready handshake and buffers results in a 2-entry FIFO for the register-file write port.
- Holds the architectural condition code register (CCR) and updates it per operation under a flag mask, including sticky-Z for extended ops.
- Evaluates the 16 standard branch conditions against the current CCR for the sequencer.

Parameters:
- DEPTH, 2, result FIFO entries. Only 2 is supported.
- CCR_RESET, 5'b00000, CCR value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept a result.
- in_result  input  32  ALU out_result.
- in_xnzvc  input  5  ALU out_xnzvc; [4]=X [3]=N [2]=Z [1]=V [0]=C.
- in_size  input  2  operation size: 00 byte, 01 word, 10 long, 11 treated as long.
- in_flag_mask  input  5  per-bit CCR update enable, same bit order as in_xnzvc.
- in_z_sticky  input  1  Z may only be cleared, never set (ADDX/SUBX/NEGX).
- ccr_wr  input  1  direct CCR write (MOVE to CCR / RTR).
- ccr_wdata  input  5  direct CCR write data.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts FIFO head.
- out_result  output  32  FIFO head result, unmodified.
- out_size  output  2  FIFO head size; 11 is normalised to 10.
- ccr  output  5  current CCR, registered.
- cond_sel  input  4  condition code select.
- cond_true  output  1  condition result, combinational from ccr.

Behaviour:
- Reset (async assert, sync-release tolerant): FIFO count=0, read/write pointers=0, out_valid=0, out_result=0, out_size=0, ccr=CCR_RESET. in_ready=1 on the first clock after deassert.
- Reset mid-operation discards buffered entries and any flag update in flight.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2), derived from the registered count with no combinational path from out_ready.
- out_valid = (count != 0). The head is registered, so latency from push to out_valid is 1 cycle.
- Count transitions: push only → count+1; pop only → count−1; push and pop at count=1 → count stays 1 and the new entry becomes head on the next cycle. Push at count=2 cannot occur.
- Pointers are 1 bit and wrap modulo 2.
- out_result and out_size are stable while out_valid=1 and out_ready=0.
- CCR update is applied on push, in the push cycle's edge, independent of FIFO drain. This keeps flags in program order.
- For each bit i with in_flag_mask[i]=1: ccr[i] <= in_xnzvc[i].
- Z exception: if in_z_sticky=1 and in_flag_mask[2]=1, ccr[2] <= ccr[2] & in_xnzvc[2].
- Masked-off bits hold their value.
- ccr_wr=1 overrides any push update in the same cycle: ccr <= ccr_wdata. The FIFO push still completes normally.
- Conditions on ccr (cond_sel → cond_true):
  - 0 T=1; 1 F=0
  - 2 HI=!C&!Z; 3 LS=C|Z
  - 4 CC=!C; 5 CS=C
  - 6 NE=!Z; 7 EQ=Z
  - 8 VC=!V; 9 VS=V
  - 10 PL=!N; 11 MI=N
  - 12 GE=N~^V; 13 LT=N^V
  - 14 GT=!Z&(N~^V); 15 LE=Z|(N^V)
- cond_true reflects the CCR after the most recent edge. A push in the current cycle is not visible until the next cycle.

Test Plan:
- Reset → out_valid=0, in_ready=1, ccr=00000. Then push in_result=8000000F, xnzvc=01010, mask=11111, size=10. Next cycle: out_valid=1, out_result=8000000F, ccr=01010; cond_sel=12 → 1, cond_sel=13 → 0, cond_sel=11 → 1.
- Hold out_ready=0 and push three results back-to-back → in_ready=0 after the second accept and the third is held. Raise out_ready → results drain in order; count never exceeds 2 and no result is lost or duplicated.
- At count=1, push and pop in the same cycle for 10 cycles with incrementing results 1..10 → out_valid stays 1, in_ready stays 1, and outputs appear in sequence.
- Set ccr to 00100 via ccr_wr, then push xnzvc=00000 with mask=00100 and z_sticky=1 → ccr Z=0. Push xnzvc=00100 with mask=00100 and z_sticky=1 → Z stays 0.
- Push xnzvc=11111 with mask=00011 → only V and C change. In the same cycle assert ccr_wr with ccr_wdata=10000 → ccr=10000.
- With two entries buffered, assert rst_n=0 mid-cycle → out_valid=0 and ccr=00000 immediately, without waiting for a clock edge. Sweep all 16 cond_sel values at ccr=00000 and 01111 and compare against the condition table.
